// File: rtl/ecc_22_err_monitor_if.sv
// ----------------------------------------------------------------------------
// ecc_22_err_monitor_if
// Bus between the 22-bit ECC decode/fault-detect stage (and its software
// control) and the error monitor.
//   decoder side : rd_vld, rd_addr, data_in, sbit_err, dbit_err, ecc_fault
//   control side : err_clr (one-cycle clear pulse)
//   monitor side : data_out, data_vld_out, data_poison, sbit_cnt, dbit_cnt,
//                  fault_cnt, log_vld, log_addr, log_type, log_ovf, irq
// master modport drives the read/clear inputs; slave modport is the monitor.
// ----------------------------------------------------------------------------
interface ecc_22_err_monitor_if #(
    parameter int DATA_WIDTH = 22,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
);
    logic                  rd_vld;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  sbit_err;
    logic                  dbit_err;
    logic                  ecc_fault;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_vld_out;
    logic                  data_poison;
    logic [CNT_WIDTH-1:0]  sbit_cnt;
    logic [CNT_WIDTH-1:0]  dbit_cnt;
    logic [CNT_WIDTH-1:0]  fault_cnt;
    logic                  log_vld;
    logic [ADDR_WIDTH-1:0] log_addr;
    logic [1:0]            log_type;
    logic                  log_ovf;
    logic                  irq;

    modport master (
        output rd_vld, rd_addr, data_in, sbit_err, dbit_err, ecc_fault, err_clr,
        input  data_out, data_vld_out, data_poison, sbit_cnt, dbit_cnt, fault_cnt,
               log_vld, log_addr, log_type, log_ovf, irq
    );

    modport slave (
        input  rd_vld, rd_addr, data_in, sbit_err, dbit_err, ecc_fault, err_clr,
        output data_out, data_vld_out, data_poison, sbit_cnt, dbit_cnt, fault_cnt,
               log_vld, log_addr, log_type, log_ovf, irq
    );
endinterface

// File: rtl/ecc_22_err_monitor.sv
// ----------------------------------------------------------------------------
// ecc_22_err_monitor
// Registered stage after the 22-bit ECC decoder. Forwards corrected data one
// cycle later with a poison tag, keeps saturating sbit/dbit/fault counters,
// logs the address/type of the first error (with overflow flag) and raises a
// sticky level interrupt until err_clr.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : ecc_22_err_monitor_if.slave (all read, clear and status signals)
// ----------------------------------------------------------------------------
module ecc_22_err_monitor #(
    parameter int DATA_WIDTH = 22,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 8,
    parameter int SBIT_THR   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ecc_22_err_monitor_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOGGED = 2'b01,
        ST_OVF    = 2'b10
    } state_t;

    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO   = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  THR        = CNT_WIDTH'(SBIT_THR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO  = {ADDR_WIDTH{1'b0}};
    localparam logic [1:0]            TYPE_NONE  = 2'b00;
    localparam logic [1:0]            TYPE_SBIT  = 2'b01;
    localparam logic [1:0]            TYPE_DBIT  = 2'b10;
    localparam logic [1:0]            TYPE_FAULT = 2'b11;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] r;
        if (v == CNT_MAX) r = CNT_MAX;
        else              r = v + CNT_ONE;
        return r;
    endfunction

    state_t                state_r, state_base_s, state_nxt_s;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  data_vld_r, poison_r;
    logic [CNT_WIDTH-1:0]  sbit_cnt_r, dbit_cnt_r, fault_cnt_r;
    logic [CNT_WIDTH-1:0]  sbit_base_s, dbit_base_s, fault_base_s;
    logic [CNT_WIDTH-1:0]  sbit_nxt_s, dbit_nxt_s, fault_nxt_s;
    logic                  log_vld_r, log_ovf_r, irq_r, irq_base_s, irq_nxt_s;
    logic [ADDR_WIDTH-1:0] log_addr_r, log_addr_base_s, log_addr_nxt_s;
    logic [1:0]            log_type_r, log_type_base_s, log_type_nxt_s;
    logic                  fault_evt_s, dbit_evt_s, sbit_evt_s, any_evt_s;
    logic [1:0]            evt_type_s;
    logic                  sbit_cross_s;

    // Event classification of the current read, fault > dbit > sbit.
    always_comb begin
        fault_evt_s = bus.rd_vld & bus.ecc_fault;
        dbit_evt_s  = bus.rd_vld & ~bus.ecc_fault & bus.dbit_err;
        sbit_evt_s  = bus.rd_vld & ~bus.ecc_fault & ~bus.dbit_err & bus.sbit_err;
        any_evt_s   = fault_evt_s | dbit_evt_s | sbit_evt_s;
        if (fault_evt_s)     evt_type_s = TYPE_FAULT;
        else if (dbit_evt_s) evt_type_s = TYPE_DBIT;
        else if (sbit_evt_s) evt_type_s = TYPE_SBIT;
        else                 evt_type_s = TYPE_NONE;
    end

    // Clear is applied before the event: build the post-clear starting state.
    always_comb begin
        state_base_s    = state_r;
        sbit_base_s     = sbit_cnt_r;
        dbit_base_s     = dbit_cnt_r;
        fault_base_s    = fault_cnt_r;
        log_addr_base_s = log_addr_r;
        log_type_base_s = log_type_r;
        irq_base_s      = irq_r;
        if (bus.err_clr) begin
            state_base_s    = ST_IDLE;
            sbit_base_s     = CNT_ZERO;
            dbit_base_s     = CNT_ZERO;
            fault_base_s    = CNT_ZERO;
            log_addr_base_s = ADDR_ZERO;
            log_type_base_s = TYPE_NONE;
            irq_base_s      = 1'b0;
        end else begin
            state_base_s    = state_r;
        end
    end

    // Log FSM next state; the first event of an idle log captures address/type.
    always_comb begin
        state_nxt_s    = state_base_s;
        log_addr_nxt_s = log_addr_base_s;
        log_type_nxt_s = log_type_base_s;
        case (state_base_s)
            ST_IDLE: begin
                if (any_evt_s) begin
                    state_nxt_s    = ST_LOGGED;
                    log_addr_nxt_s = bus.rd_addr;
                    log_type_nxt_s = evt_type_s;
                end else begin
                    state_nxt_s    = ST_IDLE;
                end
            end
            ST_LOGGED: begin
                if (any_evt_s) state_nxt_s = ST_OVF;
                else           state_nxt_s = ST_LOGGED;
            end
            ST_OVF:  state_nxt_s = ST_OVF;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Counter updates and interrupt set conditions.
    always_comb begin
        if (sbit_evt_s)  sbit_nxt_s  = sat_inc(sbit_base_s);
        else             sbit_nxt_s  = sbit_base_s;
        if (dbit_evt_s)  dbit_nxt_s  = sat_inc(dbit_base_s);
        else             dbit_nxt_s  = dbit_base_s;
        if (fault_evt_s) fault_nxt_s = sat_inc(fault_base_s);
        else             fault_nxt_s = fault_base_s;
        // Threshold fires only on the crossing, not while already above it.
        sbit_cross_s = sbit_evt_s & (sbit_nxt_s >= THR) & (sbit_base_s < THR);
        irq_nxt_s    = irq_base_s | fault_evt_s | dbit_evt_s | sbit_cross_s;
    end

    // Log FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_nxt_s;
    end

    // Data path, counters, log and interrupt registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r      <= {DATA_WIDTH{1'b0}};
            data_vld_r  <= 1'b0;
            poison_r    <= 1'b0;
            sbit_cnt_r  <= CNT_ZERO;
            dbit_cnt_r  <= CNT_ZERO;
            fault_cnt_r <= CNT_ZERO;
            log_vld_r   <= 1'b0;
            log_addr_r  <= ADDR_ZERO;
            log_type_r  <= TYPE_NONE;
            log_ovf_r   <= 1'b0;
            irq_r       <= 1'b0;
        end else begin
            if (bus.rd_vld) data_r <= bus.data_in;
            data_vld_r  <= bus.rd_vld;
            poison_r    <= fault_evt_s | dbit_evt_s;
            sbit_cnt_r  <= sbit_nxt_s;
            dbit_cnt_r  <= dbit_nxt_s;
            fault_cnt_r <= fault_nxt_s;
            log_vld_r   <= (state_nxt_s != ST_IDLE);
            log_addr_r  <= log_addr_nxt_s;
            log_type_r  <= log_type_nxt_s;
            log_ovf_r   <= (state_nxt_s == ST_OVF);
            irq_r       <= irq_nxt_s;
        end
    end

    assign bus.data_out     = data_r;
    assign bus.data_vld_out = data_vld_r;
    assign bus.data_poison  = poison_r;
    assign bus.sbit_cnt     = sbit_cnt_r;
    assign bus.dbit_cnt     = dbit_cnt_r;
    assign bus.fault_cnt    = fault_cnt_r;
    assign bus.log_vld      = log_vld_r;
    assign bus.log_addr     = log_addr_r;
    assign bus.log_type     = log_type_r;
    assign bus.log_ovf      = log_ovf_r;
    assign bus.irq          = irq_r;
endmodule
